// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs, EX/MEM and MEM/WB forwarding sources, and EX-side outputs of the ID/EX stage.
interface id_ex_if;
   logic        flush;
   logic        d_valid, d_use_rs, d_use_rt;
   logic [31:0] d_qa, d_qb, d_imm;
   logic [4:0]  d_sa, d_rs, d_rt, d_rn;
   logic [3:0]  d_aluc;
   logic        d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem;
   logic        m_wreg;
   logic [4:0]  m_rn;
   logic [31:0] m_alu;
   logic        w_wreg;
   logic [4:0]  w_rn;
   logic [31:0] w_data;
   logic [31:0] e_a, e_b, e_sdata;
   logic [3:0]  e_aluc;
   logic [4:0]  e_rn;
   logic        e_valid, e_wreg, e_m2reg, e_wmem;
   logic        stall_req;
   modport master (
      output flush, d_valid, d_use_rs, d_use_rt, d_qa, d_qb, d_imm, d_sa, d_rs, d_rt, d_rn,
             d_aluc, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem,
             m_wreg, m_rn, m_alu, w_wreg, w_rn, w_data,
      input  e_a, e_b, e_sdata, e_aluc, e_rn, e_valid, e_wreg, e_m2reg, e_wmem, stall_req
   );
   modport slave (
      input  flush, d_valid, d_use_rs, d_use_rt, d_qa, d_qb, d_imm, d_sa, d_rs, d_rt, d_rn,
             d_aluc, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem,
             m_wreg, m_rn, m_alu, w_wreg, w_rn, w_data,
      output e_a, e_b, e_sdata, e_aluc, e_rn, e_valid, e_wreg, e_m2reg, e_wmem, stall_req
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
module id_ex_stage (
   input logic    clock,
   input logic    reset,
   id_ex_if.slave bus
);
   logic        valid, aluimm, shift, wreg, m2reg, wmem, stall;
   logic [31:0] qa, qb, imm, fa, fb;
   logic [4:0]  sa, rs, rt, rn;
   logic [3:0]  aluc;
   // A load in EX cannot supply its data yet, so a dependent ID instruction waits one cycle.
   always_comb begin
      stall = !bus.flush && bus.d_valid && valid && m2reg && rn != 5'd0 &&
              ((bus.d_use_rs && rn == bus.d_rs) || (bus.d_use_rt && rn == bus.d_rt));
      fa = (bus.m_wreg && bus.m_rn != 5'd0 && bus.m_rn == rs) ? bus.m_alu :
           (bus.w_wreg && bus.w_rn != 5'd0 && bus.w_rn == rs) ? bus.w_data : qa;
      fb = (bus.m_wreg && bus.m_rn != 5'd0 && bus.m_rn == rt) ? bus.m_alu :
           (bus.w_wreg && bus.w_rn != 5'd0 && bus.w_rn == rt) ? bus.w_data : qb;
   end
   always_ff @(posedge clock) begin
      if (reset || bus.flush || stall) begin
         valid  <= 1'b0;
         qa     <= '0;
         qb     <= '0;
         imm    <= '0;
         sa     <= '0;
         rs     <= '0;
         rt     <= '0;
         rn     <= '0;
         aluc   <= '0;
         aluimm <= 1'b0;
         shift  <= 1'b0;
         wreg   <= 1'b0;
         m2reg  <= 1'b0;
         wmem   <= 1'b0;
      end else begin
         valid  <= bus.d_valid;
         qa     <= bus.d_qa;
         qb     <= bus.d_qb;
         imm    <= bus.d_imm;
         sa     <= bus.d_sa;
         rs     <= bus.d_rs;
         rt     <= bus.d_rt;
         rn     <= bus.d_rn;
         aluc   <= bus.d_aluc;
         aluimm <= bus.d_aluimm;
         shift  <= bus.d_shift;
         wreg   <= bus.d_valid & bus.d_wreg;
         m2reg  <= bus.d_valid & bus.d_m2reg;
         wmem   <= bus.d_valid & bus.d_wmem;
      end
   end
   assign bus.stall_req = stall;
   assign bus.e_a       = shift ? {27'b0, sa} : fa;
   assign bus.e_b       = aluimm ? imm : fb;
   assign bus.e_sdata   = fb;
   assign bus.e_aluc    = aluc;
   assign bus.e_rn      = rn;
   assign bus.e_valid   = valid;
   assign bus.e_wreg    = wreg;
   assign bus.e_m2reg   = m2reg;
   assign bus.e_wmem    = wmem;
endmodule
